// File: rtl/aes_display_sequencer.sv
// aes_display_sequencer: picks one of three 128-bit AES values (plaintext,
// key, ciphertext) by round-robin valid/ready arbitration, latches it for the
// seven-segment driver and steps a 32-bit page select on a dwell timer or a
// debounced push-button. A second button toggles a lock that refuses capture.
module aes_display_sequencer #(
    parameter int DWELL_CYCLES    = 200_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   src_valid,
    input  logic [383:0] src_data,
    output logic [2:0]   src_ready,
    input  logic         btn_next,
    input  logic         btn_lock,
    input  logic         auto_en,
    output logic [127:0] disp_data,
    output logic [2:0]   digit_sel,
    output logic [1:0]   src_id,
    output logic         has_data,
    output logic         locked
);
    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is "next page", index 1 is "toggle lock".
    localparam int BTN_NEXT = 0;
    localparam int BTN_LOCK = 1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SHOW   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]      sync1, sync2, deb, pulse;
    logic [DB_W-1:0] cnt [2];

    logic [1:0]      last;
    logic [1:0]      c0, c1, c2;
    logic [1:0]      grant_idx;
    logic            xfer;
    logic [127:0]    grant_data;
    logic [1:0]      page;
    logic [DW_W-1:0] dwell;

    // Synchronize both buttons, accept a new level only after it has been
    // stable for DEBOUNCE_CYCLES samples, and emit a pulse on each press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {btn_lock, btn_next};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_MAX) begin
                    cnt[i]   <= '0;
                    deb[i]   <= sync2[i];
                    pulse[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Round-robin grant starting after the last served source, plus next state.
    // A lock press in the same cycle as a transfer still lets the transfer land.
    always_comb begin
        state_next = state;
        xfer       = 1'b0;
        c0         = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c1         = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        c2         = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        grant_idx  = c0;
        if (state != LOCKED) begin
            if (src_valid[c0]) begin
                grant_idx = c0;
                xfer      = 1'b1;
            end else if (src_valid[c1]) begin
                grant_idx = c1;
                xfer      = 1'b1;
            end else if (src_valid[c2]) begin
                grant_idx = c2;
                xfer      = 1'b1;
            end
        end
        src_ready = xfer ? (3'b001 << grant_idx) : 3'b000;
        unique case (state)
            EMPTY:   if (xfer) state_next = SHOW;
            SHOW:    if (pulse[BTN_LOCK]) state_next = LOCKED;
            LOCKED:  if (pulse[BTN_LOCK]) state_next = SHOW;
            default: state_next = EMPTY;
        endcase
    end

    // Slice of the granted source.
    always_comb begin
        grant_data = src_data[127:0];
        unique case (grant_idx)
            2'd1:    grant_data = src_data[255:128];
            2'd2:    grant_data = src_data[383:256];
            default: grant_data = src_data[127:0];
        endcase
    end

    // Capture and page stepping: transfer beats manual step beats dwell expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= '0;
            src_id    <= '0;
            last      <= 2'd2;
            page      <= '0;
            dwell     <= '0;
        end else if (xfer) begin
            disp_data <= grant_data;
            src_id    <= grant_idx;
            last      <= grant_idx;
            page      <= '0;
            dwell     <= '0;
        end else if (state == EMPTY) begin
            page  <= '0;
            dwell <= '0;
        end else if (pulse[BTN_NEXT]) begin
            page  <= page + 2'd1;
            dwell <= '0;
        end else if (auto_en) begin
            if (dwell == DW_MAX) begin
                page  <= page + 2'd1;
                dwell <= '0;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign digit_sel = {1'b0, page};
    assign has_data  = (state != EMPTY);
    assign locked    = (state == LOCKED);

endmodule
